reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter_if.sv | 27 ++
 rtl/reg_write_arbiter.sv | 74 +++++++
 tb/tb_reg_write_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
// Shared register-file write port: four requesters on packed slices, one arbitrated write side.
interface reg_write_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
);
  localparam int unsigned NREQ = 4;

  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  stall;
  logic [NREQ-1:0]       gnt;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic                  busy;

  modport master (
    output req, req_addr, req_data, stall,
    input  gnt, wr_en, wr_addr, wr_data, busy
  );

  modport slave (
    input  req, req_addr, req_data, stall,
    output gnt, wr_en, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one of four requesters a single-cycle write into a register file.
// Register 0 is read-only: such writes are granted but issued with wr_en low.
module reg_write_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic               clk,
  input  logic               clr_n,
  reg_write_arbiter_if.slave bus
);
  localparam int unsigned NREQ = 4;
  localparam int unsigned PW   = 2;

  logic [NREQ-1:0]  r_gnt;
  logic             r_wr_en;
  logic [AW-1:0]    r_wr_addr;
  logic [WIDTH-1:0] r_wr_data;
  logic [PW-1:0]    r_ptr;

  logic [NREQ-1:0]  w_elig;
  logic             w_found;
  logic             w_grant;
  logic [PW-1:0]    w_win;
  logic [AW-1:0]    w_addr_a [NREQ];
  logic [WIDTH-1:0] w_data_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_addr_a[g] = bus.req_addr[g*AW +: AW];
    assign w_data_a[g] = bus.req_data[g*WIDTH +: WIDTH];
  end

  // A requester holding its grant this cycle is masked so a lingering req is not re-granted.
  assign w_elig = bus.req & ~r_gnt;

  // First eligible requester scanning from the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_elig[r_ptr + PW'(k)]) begin
        w_found = 1'b1;
        w_win   = r_ptr + PW'(k);
      end
    end
  end

  assign w_grant = w_found && !bus.stall;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_gnt     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_ptr     <= '0;
    end else begin
      r_gnt   <= '0;
      r_wr_en <= 1'b0;
      if (w_grant) begin
        r_gnt     <= NREQ'(1) << w_win;
        r_wr_en   <= (w_addr_a[w_win] != '0);
        r_wr_addr <= w_addr_a[w_win];
        r_wr_data <= w_data_a[w_win];
        r_ptr     <= w_win + PW'(1);
      end
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign bus.busy    = |w_elig;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus randomized traffic
// against a queue-free behavioural model of the round-robin grant rules.
module tb_reg_write_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned N     = 4;

  logic clk   = 1'b0;
  logic clr_n = 1'b1;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
  reg_write_arbiter #(.WIDTH(WIDTH), .AW(AW)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int mon_fail = 0;

  logic [N-1:0]     t_req;
  logic             t_stall;
  logic [AW-1:0]    t_addr [N];
  logic [WIDTH-1:0] t_data [N];

  int               m_ptr;
  logic [N-1:0]     m_gnt;
  logic             m_wr_en;
  logic [AW-1:0]    m_addr;
  logic [WIDTH-1:0] m_data;

  int wait_c [N];

  // Protocol monitor: one-hot-or-zero grant, write implies grant, bounded wait.
  always @(negedge clk) begin
    if (clr_n) begin
      assert ($onehot0(bus.gnt)) else begin
        mon_fail++;
        $display("FAIL onehot_gnt: gnt=%b required one-hot or zero", bus.gnt);
      end
      assert (!(bus.wr_en && bus.gnt == '0)) else begin
        mon_fail++;
        $display("FAIL wr_en_without_gnt: wr_en=%b gnt=%b required gnt nonzero", bus.wr_en, bus.gnt);
      end
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] || bus.stall || bus.gnt[i]) wait_c[i] = 0;
        else begin
          wait_c[i]++;
          assert (wait_c[i] <= 4) else begin
            mon_fail++;
            $display("FAIL fairness req%0d: waited %0d edges, required <= 4", i, wait_c[i]);
          end
        end
      end
    end else begin
      for (int i = 0; i < N; i++) wait_c[i] = 0;
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]       = t_addr[i];
      bus.req_data[i*WIDTH +: WIDTH] = t_data[i];
    end
    bus.req   = t_req;
    bus.stall = t_stall;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_gnt = '0; m_wr_en = 1'b0; m_addr = '0; m_data = '0;
  endtask

  // Model: first requester at or after ptr that asks and is not holding a grant wins.
  task automatic model_edge();
    int w;
    w = -1;
    if (!t_stall)
      for (int k = 0; k < N; k++)
        if (w < 0 && t_req[(m_ptr + k) % N] && !m_gnt[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    if (w >= 0) begin
      m_gnt    = '0;
      m_gnt[w] = 1'b1;
      m_addr   = t_addr[w];
      m_data   = t_data[w];
      m_wr_en  = (t_addr[w] != '0);
      m_ptr    = (w + 1) % N;
    end else begin
      m_gnt   = '0;
      m_wr_en = 1'b0;
    end
  endtask

  task automatic tick();
    drive();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    t_req = '0; t_stall = 1'b0;
    for (int i = 0; i < N; i++) begin t_addr[i] = '0; t_data[i] = '0; end
    drive();
    #1 clr_n = 1'b0;
    model_reset();
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    clr_n = 1'b1;
    do_reset();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.wr_en !== 1'b0 || bus.wr_addr !== '0 || bus.wr_data !== '0) begin
      failures++;
      $display("FAIL reset_state: gnt=%b wr_en=%b addr=%0d data=%h required all zero",
               bus.gnt, bus.wr_en, bus.wr_addr, bus.wr_data);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_idle: busy=%b required 0", bus.busy);
    end
    t_req = 4'b0001; t_addr[0] = 5'd3; drive(); #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_on_req: busy=%b required 1", bus.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] eg;
    do_reset();
    t_req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      t_addr[i] = AW'(i + 1);
      t_data[i] = WIDTH'(32'hA + i);
    end
    for (int k = 0; k < N; k++) begin
      tick();
      eg = 4'b0001 << k;
      checks++;
      if (bus.gnt !== eg || bus.wr_en !== 1'b1 || bus.wr_addr !== AW'(k + 1) || bus.wr_data !== WIDTH'(32'hA + k)) begin
        failures++;
        $display("FAIL round_robin step%0d: gnt=%b wr_en=%b addr=%0d data=%h required gnt=%b wr_en=1 addr=%0d data=%h",
                 k, bus.gnt, bus.wr_en, bus.wr_addr, bus.wr_data, eg, k + 1, 32'hA + k);
      end
    end
  endtask

  task automatic test_sole_requester();
    logic [N-1:0] eg;
    do_reset();
    t_req = 4'b0100; t_addr[2] = 5'd7; t_data[2] = $urandom;
    for (int k = 0; k < 8; k++) begin
      tick();
      eg = (k % 2 == 0) ? 4'b0100 : 4'b0000;
      checks++;
      if (bus.gnt !== eg || bus.wr_en !== eg[2]) begin
        failures++;
        $display("FAIL sole_requester cyc%0d: gnt=%b wr_en=%b required gnt=%b wr_en=%b",
                 k, bus.gnt, bus.wr_en, eg, eg[2]);
      end
    end
  endtask

  task automatic test_addr_zero();
    do_reset();
    t_req = 4'b0010; t_addr[1] = '0; t_data[1] = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (bus.gnt !== 4'b0010 || bus.wr_en !== 1'b0 || bus.wr_data !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL addr_zero: gnt=%b wr_en=%b data=%h required gnt=0010 wr_en=0 data=ffffffff",
               bus.gnt, bus.wr_en, bus.wr_data);
    end
    t_req = 4'b0110; t_addr[2] = 5'd9; t_data[2] = 32'h1234_5678;
    tick();
    checks++;
    if (bus.gnt !== 4'b0100 || bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd9) begin
      failures++;
      $display("FAIL addr_zero_next: gnt=%b wr_en=%b addr=%0d required gnt=0100 wr_en=1 addr=9",
               bus.gnt, bus.wr_en, bus.wr_addr);
    end
    tick();
    checks++;
    if (bus.gnt !== 4'b0010 || bus.wr_en !== 1'b0 || bus.wr_addr !== 5'd0) begin
      failures++;
      $display("FAIL addr_zero_wrap: gnt=%b wr_en=%b addr=%0d required gnt=0010 wr_en=0 addr=0",
               bus.gnt, bus.wr_en, bus.wr_addr);
    end
  endtask

  task automatic test_stall();
    do_reset();
    t_stall = 1'b1; t_req = 4'b1001;
    t_addr[0] = 5'd11; t_data[0] = 32'hCAFE_0000;
    t_addr[3] = 5'd12; t_data[3] = 32'hCAFE_0003;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.gnt !== 4'b0000 || bus.wr_en !== 1'b0 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_block cyc%0d: gnt=%b wr_en=%b busy=%b required gnt=0000 wr_en=0 busy=1",
                 k, bus.gnt, bus.wr_en, bus.busy);
      end
    end
    t_stall = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.wr_addr !== 5'd11) begin
      failures++;
      $display("FAIL stall_release: gnt=%b addr=%0d required gnt=0001 addr=11", bus.gnt, bus.wr_addr);
    end
    t_stall = 1'b1; drive(); #1;
    checks++;
    if (bus.gnt !== 4'b0001 || bus.wr_en !== 1'b1) begin
      failures++;
      $display("FAIL stall_keeps_grant: gnt=%b wr_en=%b required gnt=0001 wr_en=1", bus.gnt, bus.wr_en);
    end
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.wr_en !== 1'b0) begin
      failures++;
      $display("FAIL stall_after_grant: gnt=%b wr_en=%b required 0000/0", bus.gnt, bus.wr_en);
    end
    t_stall = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 4'b1000 || bus.wr_data !== 32'hCAFE_0003) begin
      failures++;
      $display("FAIL stall_resume_rr: gnt=%b data=%h required gnt=1000 data=cafe0003", bus.gnt, bus.wr_data);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    t_req = 4'b0100; t_addr[2] = 5'd5; t_data[2] = 32'h5555_AAAA;
    tick();
    checks++;
    if (bus.gnt !== 4'b0100) begin
      failures++;
      $display("FAIL mid_reset_setup: gnt=%b required 0100", bus.gnt);
    end
    #2 clr_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.gnt !== 4'b0000 || bus.wr_en !== 1'b0 || bus.wr_addr !== '0 || bus.wr_data !== '0) begin
      failures++;
      $display("FAIL async_reset: gnt=%b wr_en=%b addr=%0d data=%h required all zero",
               bus.gnt, bus.wr_en, bus.wr_addr, bus.wr_data);
    end
    @(negedge clk);
    clr_n = 1'b1;
    t_req = 4'b0110; t_addr[1] = 5'd3; t_data[1] = 32'h3333_3333;
    tick();
    checks++;
    if (bus.gnt !== 4'b0010 || bus.wr_addr !== 5'd3) begin
      failures++;
      $display("FAIL after_reset_first: gnt=%b addr=%0d required gnt=0010 addr=3", bus.gnt, bus.wr_addr);
    end
  endtask

  task automatic test_random();
    logic eb;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (t_req[i]) begin
          if (m_gnt[i]) begin
            if ($urandom_range(0, 1) == 0) t_req[i] = 1'b0;
            else begin t_addr[i] = AW'($urandom_range(0, 31)); t_data[i] = $urandom; end
          end else if ($urandom_range(0, 19) == 0) t_req[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 4) begin
          t_req[i]  = 1'b1;
          t_addr[i] = AW'($urandom_range(0, 31));
          t_data[i] = $urandom;
        end
      end
      t_stall = ($urandom_range(0, 4) == 0);
      drive(); #1;
      eb = |(t_req & ~m_gnt);
      checks++;
      if (bus.busy !== eb) begin
        failures++;
        $display("FAIL random_busy cyc%0d: busy=%b required %b", c, bus.busy, eb);
      end
      tick();
      checks++;
      if (bus.gnt !== m_gnt || bus.wr_en !== m_wr_en || bus.wr_addr !== m_addr || bus.wr_data !== m_data) begin
        failures++;
        $display("FAIL random cyc%0d: gnt=%b wr_en=%b addr=%0d data=%h required gnt=%b wr_en=%b addr=%0d data=%h",
                 c, bus.gnt, bus.wr_en, bus.wr_addr, bus.wr_data, m_gnt, m_wr_en, m_addr, m_data);
      end
    end
  endtask

  initial begin
    t_req = '0; t_stall = 1'b0;
    for (int i = 0; i < N; i++) begin t_addr[i] = '0; t_data[i] = '0; wait_c[i] = 0; end
    drive();
    model_reset();
    test_reset();
    test_round_robin();
    test_sole_requester();
    test_addr_zero();
    test_stall();
    test_reset_mid_grant();
    test_random();
    checks++;
    if (mon_fail !== 0) begin
      failures++;
      $display("FAIL protocol_monitor: violations=%0d required 0", mon_fail);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
